// File: rtl/cell_display_pipe_if.sv
// Pixel-side bus of the cell display pipe: scan pixels in, cell memory
// address/data, and the registered colour towards the VGA core.
interface cell_display_pipe_if #(
    parameter int ADDR_W = 8
);
    logic              scan_valid;
    logic [9:0]        scan_x;
    logic [9:0]        scan_y;
    logic [ADDR_W-1:0] cell_x;
    logic [ADDR_W-1:0] cell_y;
    logic              cell_state;
    logic              in_disp_area;
    logic              disp_valid;
    logic [11:0]       disp_value_RGB;

    // Scan source, cell memory and VGA core side
    modport master (
        output scan_valid, scan_x, scan_y, cell_state,
        input  cell_x, cell_y, in_disp_area, disp_valid, disp_value_RGB
    );

    // Display pipe side
    modport slave (
        input  scan_valid, scan_x, scan_y, cell_state,
        output cell_x, cell_y, in_disp_area, disp_valid, disp_value_RGB
    );
endinterface

// File: rtl/cell_display_pipe.sv
// Maps VGA scan pixels to board cells, fetches the cell state, and produces
// a registered 12-bit colour. Zoomable, toroidally wrapped window, cursor
// blink counted in frames, configurable cell memory read latency.
`ifndef MODE_EDIT
`define MODE_EDIT 1'b1
`endif

module cell_display_pipe #(
    parameter int ADDR_W       = 8,
    parameter int PX_BOUND_LM  = 50,
    parameter int PX_BOUND_RM  = 400,
    parameter int PX_BOUND_UM  = 50,
    parameter int PX_BOUND_DM  = 400,
    parameter int MEM_LAT      = 1,
    parameter int ZOOM_MIN     = 3,
    parameter int ZOOM_MAX     = 7,
    parameter int BLINK_FRAMES = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              frame_start,
    input  logic [ADDR_W-1:0] win_x,
    input  logic [ADDR_W-1:0] win_y,
    input  logic [2:0]        zoom,
    input  logic              grid_en,
    input  logic [ADDR_W-1:0] cur_x,
    input  logic [ADDR_W-1:0] cur_y,
    cell_display_pipe_if.slave bus
);

    localparam int DW = 4 + 2 * ADDR_W;
    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // Cell palette: red/green from the low cell coordinates, blue mixes both
    function automatic logic [11:0] color_generator(input logic [ADDR_W-1:0] x,
                                                    input logic [ADDR_W-1:0] y);
        return {4'(x), 4'(y), 4'(x ^ y)};
    endfunction

    logic [3:0]        zc;
    logic [9:0]        rel_x, rel_y, rem_mask;
    logic              in_a;
    logic              a_valid, a_in, a_rx0, a_ry0;
    logic [ADDR_W-1:0] a_cx, a_cy;
    logic [DW-1:0]     a_word, b_word;
    logic              b_valid, b_in, b_rx0, b_ry0;
    logic [ADDR_W-1:0] b_cx, b_cy;
    logic [11:0]       rgb_n;
    logic              in_q, valid_q;
    logic [11:0]       rgb_q;
    logic              blink_on;
    logic [CW-1:0]     frame_cnt;
    logic [ADDR_W-1:0] cur_prev_x, cur_prev_y;
    logic              cur_moved;

    // Clamp the requested zoom into the supported range
    always_comb begin
        zc = {1'b0, zoom};
        if (zc < 4'(ZOOM_MIN))
            zc = 4'(ZOOM_MIN);
        else if (zc > 4'(ZOOM_MAX))
            zc = 4'(ZOOM_MAX);
    end

    assign rel_x    = bus.scan_x - 10'(PX_BOUND_LM);
    assign rel_y    = bus.scan_y - 10'(PX_BOUND_UM);
    assign rem_mask = (10'd1 << zc) - 10'd1;
    assign in_a     = (bus.scan_x > 10'(PX_BOUND_LM)) & (bus.scan_x < 10'(PX_BOUND_RM)) &
                      (bus.scan_y > 10'(PX_BOUND_UM)) & (bus.scan_y < 10'(PX_BOUND_DM));

    // Stage A: cell address (wrapping on the board) plus per-pixel side info
    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid <= 1'b0;
            a_in    <= 1'b0;
            a_rx0   <= 1'b0;
            a_ry0   <= 1'b0;
            a_cx    <= '0;
            a_cy    <= '0;
        end else begin
            a_valid <= bus.scan_valid;
            a_in    <= in_a;
            a_rx0   <= (rel_x & rem_mask) == 10'd0;
            a_ry0   <= (rel_y & rem_mask) == 10'd0;
            a_cx    <= win_x + ADDR_W'(rel_x >> zc);
            a_cy    <= win_y + ADDR_W'(rel_y >> zc);
        end
    end

    assign bus.cell_x = a_cx;
    assign bus.cell_y = a_cy;
    assign a_word     = {a_valid, a_in, a_rx0, a_ry0, a_cx, a_cy};

    generate
        if (MEM_LAT == 0) begin : g_no_dl
            assign b_word = a_word;
        end else begin : g_dl
            logic [DW-1:0] dl [0:MEM_LAT-1];
            // Hold pixel side info until the memory returns its cell state
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < MEM_LAT; i++)
                        dl[i] <= '0;
                end else begin
                    dl[0] <= a_word;
                    for (int i = 1; i < MEM_LAT; i++)
                        dl[i] <= dl[i-1];
                end
            end
            assign b_word = dl[MEM_LAT-1];
        end
    endgenerate

    assign {b_valid, b_in, b_rx0, b_ry0, b_cx, b_cy} = b_word;

    // Colour priority: blank, grid, blinking cursor, live cell, dead cell
    always_comb begin
        rgb_n = 12'h000;
        if (!b_valid || !b_in)
            rgb_n = 12'h000;
        else if (grid_en && (b_rx0 || b_ry0))
            rgb_n = 12'h000;
        else if (mode == `MODE_EDIT && b_cx == cur_x && b_cy == cur_y && blink_on)
            rgb_n = 12'h0F0;
        else if (bus.cell_state)
            rgb_n = color_generator(b_cx, b_cy);
        else
            rgb_n = 12'hFFF;
    end

    // Stage B: registered outputs to the VGA core
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            in_q    <= 1'b0;
            rgb_q   <= 12'h000;
        end else begin
            valid_q <= b_valid;
            in_q    <= b_in;
            rgb_q   <= rgb_n;
        end
    end

    assign bus.disp_valid     = valid_q;
    assign bus.in_disp_area   = in_q;
    assign bus.disp_value_RGB = rgb_q;

    assign cur_moved = (cur_x != cur_prev_x) || (cur_y != cur_prev_y);

    // Cursor blink: toggle every BLINK_FRAMES frames, restart lit when the cursor moves
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_on   <= 1'b1;
            frame_cnt  <= '0;
            cur_prev_x <= cur_x;
            cur_prev_y <= cur_y;
        end else begin
            cur_prev_x <= cur_x;
            cur_prev_y <= cur_y;
            if (mode != `MODE_EDIT) begin
                blink_on  <= 1'b1;
                frame_cnt <= '0;
            end else if (cur_moved) begin
                blink_on  <= 1'b1;
                frame_cnt <= '0;
            end else if (frame_start) begin
                if (frame_cnt == CW'(BLINK_FRAMES - 1)) begin
                    blink_on  <= ~blink_on;
                    frame_cnt <= '0;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cell_display_pipe.sv
// Directed bench for cell_display_pipe: expected addresses and colours are
// hand-computed per vector; monitors compare them as the DUT presents them.
module tb_cell_display_pipe;

    localparam int LAT = 1;

    typedef struct {
        int         stamp;
        logic [7:0] cx;
        logic [7:0] cy;
        logic       in;
        logic [11:0] rgb;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mode = 1'b0;
    logic       frame_start = 1'b0;
    logic [7:0] win_x = '0, win_y = '0;
    logic [2:0] zoom = 3'd3;
    logic       grid_en = 1'b0;
    logic [7:0] cur_x = '0, cur_y = '0;

    int cyc = 0;
    int n_checks = 0;
    int n_err = 0;
    exp_t aq[$];
    exp_t dq[$];

    cell_display_pipe_if #(.ADDR_W(8)) dif ();

    cell_display_pipe #(.ADDR_W(8), .MEM_LAT(LAT), .BLINK_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .mode(mode), .frame_start(frame_start),
        .win_x(win_x), .win_y(win_y), .zoom(zoom), .grid_en(grid_en),
        .cur_x(cur_x), .cur_y(cur_y), .bus(dif.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // One-cycle-latency cell memory: a cell is alive when x and y have equal parity
    initial dif.cell_state = 1'b0;
    always @(posedge clk) dif.cell_state <= ~(dif.cell_x[0] ^ dif.cell_y[0]);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Address monitor: cell_x/cell_y one cycle after the pixel is sampled
    always @(negedge clk) begin
        exp_t e;
        if (aq.size() > 0 && aq[0].stamp + 1 == cyc) begin
            e = aq.pop_front();
            chk("cell_x", 32'(dif.cell_x), 32'(e.cx));
            chk("cell_y", 32'(dif.cell_y), 32'(e.cy));
        end else if (aq.size() > 0 && aq[0].stamp + 1 < cyc) begin
            e = aq.pop_front();
            chk("addr_slot_missed", 32'(cyc), 32'(e.stamp + 1));
        end
    end

    // Display monitor: compares every presented pixel against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (dif.disp_valid === 1'b1) begin
            if (dq.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_valid: got disp_valid=1, expected 0 (cycle %0d)", cyc);
            end else begin
                e = dq.pop_front();
                chk("latency", 32'(cyc), 32'(e.stamp + 2 + LAT));
                chk("in_disp_area", 32'(dif.in_disp_area), 32'(e.in));
                chk("rgb", 32'(dif.disp_value_RGB), 32'(e.rgb));
            end
        end else if (dq.size() > 0 && dq[0].stamp + 2 + LAT < cyc) begin
            e = dq.pop_front();
            chk("disp_missing", 32'(dif.disp_valid), 32'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        dif.scan_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic issue(input logic [9:0] sx, input logic [9:0] sy,
                         input logic [7:0] ecx, input logic [7:0] ecy,
                         input logic ein, input logic [11:0] ergb);
        exp_t e;
        dif.scan_valid = 1'b1;
        dif.scan_x = sx;
        dif.scan_y = sy;
        e.stamp = cyc; e.cx = ecx; e.cy = ecy; e.in = ein; e.rgb = ergb;
        aq.push_back(e);
        dq.push_back(e);
        tick();
        dif.scan_valid = 1'b0;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
    endtask

    task automatic reset_cycles(input int n);
        rst = 1'b1;
        dif.scan_valid = 1'b1;
        aq.delete();
        dq.delete();
        repeat (n) begin
            tick();
            chk("rst_disp_valid", 32'(dif.disp_valid), 32'd0);
            chk("rst_rgb", 32'(dif.disp_value_RGB), 32'h000);
            chk("rst_cell_x", 32'(dif.cell_x), 32'd0);
        end
        rst = 1'b0;
        dif.scan_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        dif.scan_valid = 1'b0;
        dif.scan_x = 10'd83;
        dif.scan_y = 10'd60;
        win_x = 8'd2; win_y = 8'd5; zoom = 3'd3; grid_en = 1'b1;
        #1;

        // Reset with pixels present; the first post-reset pixel has full latency
        reset_cycles(3);
        issue(10'd83, 10'd60, 8'd6, 8'd6, 1'b1, 12'h660);
        issue(10'd51, 10'd60, 8'd2, 8'd6, 1'b1, 12'h264);
        idle(5);

        // Bounds are exclusive on both sides
        issue(10'd50, 10'd60, 8'd2, 8'd6, 1'b0, 12'h000);
        issue(10'd400, 10'd60, 8'd45, 8'd6, 1'b0, 12'h000);
        issue(10'd83, 10'd50, 8'd6, 8'd5, 1'b0, 12'h000);
        idle(5);

        // Zoom 4 halves the cell count; (4,5) is dead
        zoom = 3'd4;
        issue(10'd83, 10'd60, 8'd4, 8'd5, 1'b1, 12'hFFF);
        // Zoom clamp and grid line on rem_x==0
        zoom = 3'd1; win_x = 8'd0; win_y = 8'd0;
        issue(10'd58, 10'd70, 8'd1, 8'd2, 1'b1, 12'h000);
        idle(4);
        grid_en = 1'b0;
        issue(10'd58, 10'd70, 8'd1, 8'd2, 1'b1, 12'hFFF);
        idle(4);

        // Toroidal wrap of the window
        zoom = 3'd3; win_x = 8'hFE; win_y = 8'd2;
        issue(10'd75, 10'd75, 8'h01, 8'd5, 1'b1, 12'h154);
        win_y = 8'd5;
        issue(10'd75, 10'd60, 8'h01, 8'd6, 1'b1, 12'hFFF);
        idle(5);

        // Mid-operation reset drops in-flight pixels
        win_x = 8'd2; win_y = 8'd5;
        dif.scan_valid = 1'b1;
        dif.scan_x = 10'd83; dif.scan_y = 10'd60;
        tick();
        tick();
        reset_cycles(2);
        idle(6);

        // Cursor blink in edit mode, two frames per half-period
        mode = `MODE_EDIT; cur_x = 8'd6; cur_y = 8'd6;
        idle(2);
        issue(10'd83, 10'd60, 8'd6, 8'd6, 1'b1, 12'h0F0);
        idle(4); frame();
        issue(10'd83, 10'd60, 8'd6, 8'd6, 1'b1, 12'h0F0);
        idle(4); frame();
        issue(10'd83, 10'd60, 8'd6, 8'd6, 1'b1, 12'h660);
        idle(4); frame();
        issue(10'd83, 10'd60, 8'd6, 8'd6, 1'b1, 12'h660);
        idle(4); frame();
        issue(10'd83, 10'd60, 8'd6, 8'd6, 1'b1, 12'h0F0);
        idle(4); frame(); frame();
        issue(10'd83, 10'd60, 8'd6, 8'd6, 1'b1, 12'h660);
        idle(4);

        // Moving the cursor during the off phase relights it immediately
        cur_x = 8'd7;
        idle(1);
        issue(10'd91, 10'd60, 8'd7, 8'd6, 1'b1, 12'h0F0);
        idle(4);

        // Outside edit mode the cursor never shows
        mode = 1'b0; cur_x = 8'd6;
        idle(1);
        issue(10'd83, 10'd60, 8'd6, 8'd6, 1'b1, 12'h660);
        idle(4); frame(); frame();
        issue(10'd83, 10'd60, 8'd6, 8'd6, 1'b1, 12'h660);
        issue(10'd91, 10'd60, 8'd7, 8'd6, 1'b1, 12'hFFF);
        idle(8);

        chk("addr_queue_drained", 32'(aq.size()), 32'd0);
        chk("disp_queue_drained", 32'(dq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
